vu_level: RTL and testbench
===========================

# vu_level

Downstream consumer of the UART receiver's byte stream. Each received byte is an offset-binary audio sample. The block turns it into a magnitude, tracks a peak level with hold and linear decay, and drives a registered thermometer-coded LED bar plus a clip flag. It runs in the same clock domain as the receiver's `data`/`data_valid` outputs, so no CDC is required.

## Interface
- `NUM_LEDS`, 8: bar length. Legal values are powers of two, 2..64.
- `HOLD_CYCLES`, 500000: clocks the peak is held after the last refresh.
- `DECAY_CYCLES`, 20000: clocks per 1-LSB level decrement during decay. Must be ≥ 1.
- `clk`, input, 1: block clock, same clock that drives the UART receiver.
- `rst`, input, 1: asynchronous, active-low reset.
- `data`, input, 8: received byte, offset binary (0x80 = silence).
- `data_valid`, input, 1: single-cycle strobe; `data` is valid in that cycle.
- `level`, output, 7: current peak level, 0..127.
- `led`, output, NUM_LEDS: thermometer bar; `led[0]` is the lowest segment.
- `clip`, output, 1: asserted while `level` == 127.

## Operation
- **Magnitude:** `mag` = |data − 128|, saturated to 127.
  - 0x00 → 127 (saturated from 128).
  - 0x01 → 127.
  - 0xFF → 127.
  - 0x80 → 0.
- **States:** IDLE, HOLD, DECAY.
- **IDLE:**
  - Entered when `level` == 0.
  - A strobe with `mag` > 0 → `level` = `mag`, hold counter = HOLD_CYCLES − 1, go to HOLD.
  - A strobe with `mag` == 0 is ignored.
- **HOLD:**
  - The hold counter decrements every clock.
  - A strobe with `mag` ≥ `level` → `level` = `mag` and the counter reloads.
  - A strobe with `mag` < `level` is ignored.
  - Counter == 0 with no refresh in the same cycle → go to DECAY, decay counter = DECAY_CYCLES − 1.
- **DECAY:**
  - The decay counter decrements every clock.
  - At 0: `level` −= 1 and the counter reloads.
  - A decrement that reaches 0 → go to IDLE.
  - A strobe with `mag` ≥ `level` → `level` = `mag`, go to HOLD with the hold counter reloaded.
- **Simultaneous events:** a qualifying strobe always wins over a hold expiry or decay tick in the same cycle. No decrement happens in that cycle.
- **Bar:** `count` = ((`level` + 1) × NUM_LEDS) >> 7; `led[i]` = (i < `count`).
  - With NUM_LEDS = 8: `level` 0..14 → 0 LEDs; 15 → 1 LED; 127 → 8 LEDs (all).
- **Clip:** `clip` is registered from the next-state `level` == 127.
- **Reset:** asynchronous assertion at any time, including mid-hold or mid-decay, forces:
  - state = IDLE;
  - both counters = 0;
  - `level` = 0;
  - `led` = 0;
  - `clip` = 0.

  Operation resumes on the first clock edge after deassertion.

## Timing
- A strobe in cycle N → `level` and `clip` updated at edge N+1.
- `led` updates at edge N+2, because the bar has one extra register stage.
- Hold duration: a strobe at cycle N (not refreshed) leaves `level` unchanged through edge N+HOLD_CYCLES. The first decrement occurs at edge N+HOLD_CYCLES+DECAY_CYCLES.
- Full decay from 127 to 0 takes 127 × DECAY_CYCLES clocks after hold expiry.
- No backpressure: every strobe is consumed in its cycle. Strobes on consecutive cycles are legal.

## Structure
- **Package `vu_pkg`:**
  - state enum (IDLE, HOLD, DECAY);
  - `LEVEL_W` = 7 and `SILENCE` = 8'h80 constants;
  - the offset-binary-to-magnitude function.
- **Sub-module `vu_bar_decoder`:** parameterised by NUM_LEDS. Takes `level` and produces the registered thermometer `led` vector.
- Counter widths are $clog2 of the corresponding parameter, minimum 1.

## Test plan
All scenarios use HOLD_CYCLES = 10, DECAY_CYCLES = 4, NUM_LEDS = 8.

- **Reset:** hold `rst` low, drive random strobes → `level` = 0, `led` = 8'h00, `clip` = 0. Release → still 0 until the first strobe.
- **Single peak:** strobe 0xC0 at cycle N →
  - `level` = 64 at N+1;
  - `led` = 8'h0F at N+2;
  - `level` unchanged through N+10;
  - `level` = 63 at N+14;
  - `level` = 0 and state IDLE after 64 × 4 further clocks.
- **Refresh and ignore:**
  - Strobe 0x20 → `level` = 96.
  - Strobe 0x90 (mag 16) 3 cycles later → ignored.
  - Strobe 0x20 again at cycle 5 → hold restarts; first decrement occurs 14 clocks after that strobe.
- **Collision:** during DECAY with `level` = 40, present strobe 0x58 (mag 40) in the same cycle as a decay tick → `level` stays 40, state becomes HOLD.
- **Clip and saturation:**
  - Strobe 0x00 → `level` = 127, `clip` = 1, `led` = 8'hFF.
  - Strobe 0xFF → `level` = 127.
  - After hold plus one decay tick → `level` = 126, `clip` = 0.
- **Reset mid-decay:** assert `rst` asynchronously between clock edges while `level` = 50 → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/vu_pkg.sv
// rtl/vu_pkg.sv - shared types, constants and magnitude helper for the VU meter
// Purpose: state encoding, level width, silence code and the
//          offset-binary to magnitude conversion used by vu_level.
// Ports:   none (package)
package vu_pkg;

   localparam int         LEVEL_W = 7;
   localparam logic [7:0] SILENCE = 8'h80;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      DECAY = 2'd2
   } vu_state_e;

   // |d - 128|, saturated to 127 so that 0x00 (distance 128) still fits in LEVEL_W bits.
   function automatic logic [LEVEL_W-1:0] vu_mag(input logic [7:0] d);
      logic [7:0] m;
      m = d[7] ? (d - SILENCE) : (SILENCE - d);
      return m[7] ? {LEVEL_W{1'b1}} : m[LEVEL_W-1:0];
   endfunction

endpackage

// File: rtl/vu_bar_decoder.sv
// rtl/vu_bar_decoder.sv - registered thermometer decoder for the LED bar
// Purpose: converts a 0..127 level into NUM_LEDS thermometer-coded segments.
// Ports:   clk   - block clock
//          rst   - asynchronous active-low reset
//          level - current peak level
//          led   - registered bar, led[0] is the lowest segment
module vu_bar_decoder
   import vu_pkg::*;
#(
   parameter int NUM_LEDS = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [LEVEL_W-1:0]  level,
   output logic [NUM_LEDS-1:0] led
);

   int                  cnt;
   logic [NUM_LEDS-1:0] led_d;
   logic [NUM_LEDS-1:0] led_q;

   // Segments lit = ((level + 1) * NUM_LEDS) / 128, so full scale lights every segment.
   always_comb begin
      cnt   = ((int'(level) + 1) * NUM_LEDS) >> LEVEL_W;
      led_d = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         led_d[i] = (i < cnt);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led_q <= '0;
      end else begin
         led_q <= led_d;
      end
   end

   assign led = led_q;

endmodule

// File: rtl/vu_level.sv
// rtl/vu_level.sv - peak level meter with hold, linear decay, LED bar and clip flag
// Purpose: takes offset-binary bytes from the UART receiver, tracks the peak
//          magnitude, holds it, then decays it one LSB per DECAY_CYCLES clocks.
// Ports:   clk        - block clock (same domain as the receiver)
//          rst        - asynchronous active-low reset
//          data       - received byte, offset binary (0x80 = silence)
//          data_valid - single-cycle strobe qualifying data
//          level      - current peak level, 0..127
//          led        - thermometer bar, one register stage behind level
//          clip       - high while level is 127
module vu_level
   import vu_pkg::*;
#(
   parameter int NUM_LEDS     = 8,
   parameter int HOLD_CYCLES  = 500000,
   parameter int DECAY_CYCLES = 20000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          data,
   input  logic                data_valid,
   output logic [LEVEL_W-1:0]  level,
   output logic [NUM_LEDS-1:0] led,
   output logic                clip
);

   localparam int HOLD_W  = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
   localparam int DECAY_W = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;

   localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [DECAY_W-1:0] DECAY_LOAD = DECAY_W'(DECAY_CYCLES - 1);
   localparam logic [LEVEL_W-1:0] LEVEL_MAX  = {LEVEL_W{1'b1}};
   localparam logic [LEVEL_W-1:0] LEVEL_ONE  = LEVEL_W'(1);

   vu_state_e            state_q, state_d;
   logic [LEVEL_W-1:0]   level_q, level_d;
   logic [HOLD_W-1:0]    hold_q,  hold_d;
   logic [DECAY_W-1:0]   decay_q, decay_d;
   logic                 clip_q;
   logic [LEVEL_W-1:0]   mag;
   logic                 refresh;

   assign mag     = vu_mag(data);
   assign refresh = data_valid && (mag >= level_q);

   // Refresh is tested first in every state, so a qualifying strobe always beats
   // a hold expiry or decay tick in the same cycle.
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      hold_d  = hold_q;
      decay_d = decay_q;
      case (state_q)
         IDLE: begin
            if (data_valid && (mag != '0)) begin
               level_d = mag;
               hold_d  = HOLD_LOAD;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (refresh) begin
               level_d = mag;
               hold_d  = HOLD_LOAD;
            end else if (hold_q <= HOLD_W'(1)) begin
               // Leave on the edge where the counter lands on zero, so the level
               // is held for HOLD_CYCLES edges counting the load edge.
               hold_d  = '0;
               decay_d = DECAY_LOAD;
               state_d = DECAY;
            end else begin
               hold_d = hold_q - HOLD_W'(1);
            end
         end
         DECAY: begin
            if (refresh) begin
               level_d = mag;
               hold_d  = HOLD_LOAD;
               decay_d = '0;
               state_d = HOLD;
            end else if (decay_q == '0) begin
               level_d = level_q - LEVEL_ONE;
               if (level_q == LEVEL_ONE) begin
                  decay_d = '0;
                  state_d = IDLE;
               end else begin
                  decay_d = DECAY_LOAD;
               end
            end else begin
               decay_d = decay_q - DECAY_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            level_d = '0;
            hold_d  = '0;
            decay_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         level_q <= '0;
         hold_q  <= '0;
         decay_q <= '0;
         clip_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         hold_q  <= hold_d;
         decay_q <= decay_d;
         clip_q  <= (level_d == LEVEL_MAX);
      end
   end

   vu_bar_decoder #(
      .NUM_LEDS (NUM_LEDS)
   ) u_bar (
      .clk   (clk),
      .rst   (rst),
      .level (level_q),
      .led   (led)
   );

   assign level = level_q;
   assign clip  = clip_q;

endmodule

// File: tb/tb_vu_level.sv
// tb/tb_vu_level.sv - directed self-checking bench for vu_level
module tb_vu_level;
   import vu_pkg::*;

   logic       clk;
   logic       rst;
   logic [7:0] data;
   logic       data_valid;
   logic [6:0] level;
   logic [7:0] led;
   logic       clip;

   int n_checks;
   int n_fail;

   vu_level #(
      .NUM_LEDS     (8),
      .HOLD_CYCLES  (10),
      .DECAY_CYCLES (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .data       (data),
      .data_valid (data_valid),
      .level      (level),
      .led        (led),
      .clip       (clip)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Strobe in the current cycle; returns 1 time unit after the sampling edge.
   task automatic strobe(input logic [7:0] b);
      data       = b;
      data_valid = 1'b1;
      @(posedge clk);
      #1;
      data_valid = 1'b0;
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      rst        = 1'b0;
      data       = 8'h00;
      data_valid = 1'b0;

      // Reset held with strobes flowing
      for (int k = 0; k < 6; k++) begin
         data       = 8'($urandom);
         data_valid = 1'b1;
         tick(1);
      end
      data_valid = 1'b0;
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_led",   32'(led),   32'h00);
      chk("rst_clip",  32'(clip),  32'd0);
      rst = 1'b1;
      tick(3);
      chk("post_rst_level", 32'(level), 32'd0);
      chk("post_rst_led",   32'(led),   32'h00);
      strobe(8'h80);
      chk("idle_silence_ignored", 32'(level), 32'd0);
      chk("idle_silence_state",   32'(dut.state_q), 32'(IDLE));

      // Single peak 0xC0 -> 64; strobe cycle is N
      strobe(8'hC0);
      chk("peak_n1_level", 32'(level), 32'd64);
      chk("peak_n1_clip",  32'(clip),  32'd0);
      tick(1);
      chk("peak_n2_led",   32'(led),   32'h0F);
      tick(8);
      chk("peak_n10_level", 32'(level), 32'd64);
      tick(3);
      chk("peak_n13_level", 32'(level), 32'd64);
      tick(1);
      chk("peak_n14_level", 32'(level), 32'd63);
      tick(4);
      chk("peak_n18_level", 32'(level), 32'd62);
      tick(247);
      chk("peak_n265_level", 32'(level), 32'd1);
      tick(1);
      chk("peak_n266_level", 32'(level), 32'd0);
      chk("peak_n266_state", 32'(dut.state_q), 32'(IDLE));

      // Refresh and ignore: strobe at cycle 0, ignored at 3, refresh at 5
      strobe(8'h20);
      chk("refr_e1_level", 32'(level), 32'd96);
      tick(1);
      chk("refr_e2_led",   32'(led),   32'h3F);
      tick(1);
      strobe(8'h90);
      chk("refr_small_ignored", 32'(level), 32'd96);
      tick(1);
      strobe(8'h20);
      chk("refr_e6_level", 32'(level), 32'd96);
      tick(12);
      chk("refr_e18_level", 32'(level), 32'd96);
      tick(1);
      chk("refr_e19_level", 32'(level), 32'd95);
      chk("refr_e19_state", 32'(dut.state_q), 32'(DECAY));

      // Collision: level 40 at edge 239, decay tick falls in the cycle ending at edge 243
      tick(220);
      chk("coll_e239_level", 32'(level), 32'd40);
      tick(3);
      strobe(8'h58);
      chk("coll_level", 32'(level), 32'd40);
      chk("coll_state", 32'(dut.state_q), 32'(HOLD));
      tick(12);
      chk("coll_hold_level", 32'(level), 32'd40);
      tick(1);
      chk("coll_first_dec",  32'(level), 32'd39);

      // Clip and saturation
      strobe(8'h00);
      chk("sat00_level", 32'(level), 32'd127);
      chk("sat00_clip",  32'(clip),  32'd1);
      strobe(8'hFF);
      chk("satff_level", 32'(level), 32'd127);
      chk("satff_led",   32'(led),   32'hFF);
      tick(12);
      chk("clip_hold_level", 32'(level), 32'd127);
      chk("clip_hold_clip",  32'(clip),  32'd1);
      tick(1);
      chk("clip_dec_level", 32'(level), 32'd126);
      chk("clip_dec_clip",  32'(clip),  32'd0);
      tick(1);
      chk("clip_dec_led",   32'(led),   32'h7F);
      strobe(8'h01);
      chk("sat01_level", 32'(level), 32'd127);
      chk("sat01_clip",  32'(clip),  32'd1);
      strobe(8'h80);
      chk("hold_silence_ignored", 32'(level), 32'd127);

      // Asynchronous reset mid-hold, between edges
      #2;
      rst = 1'b0;
      #1;
      chk("arst_hold_level", 32'(level), 32'd0);
      chk("arst_hold_led",   32'(led),   32'h00);
      chk("arst_hold_clip",  32'(clip),  32'd0);
      tick(1);
      rst = 1'b1;
      tick(2);
      chk("arst_hold_after", 32'(level), 32'd0);

      // Reset mid-decay at level 50
      strobe(8'hB3);
      chk("mid_n1_level", 32'(level), 32'd51);
      tick(13);
      chk("mid_n14_level", 32'(level), 32'd50);
      chk("mid_n14_led",   32'(led),   32'h07);
      chk("mid_n14_state", 32'(dut.state_q), 32'(DECAY));
      tick(1);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_dec_level", 32'(level), 32'd0);
      chk("arst_dec_led",   32'(led),   32'h00);
      chk("arst_dec_clip",  32'(clip),  32'd0);
      chk("arst_dec_state", 32'(dut.state_q), 32'(IDLE));
      tick(2);
      rst = 1'b1;
      tick(3);
      chk("arst_dec_after", 32'(level), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
